// File: rtl/device_arb_pkg.sv
// Shared types for the Device port arbiter: FSM encoding and the latched request record.
package device_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic        func;
        logic [3:0]  strb;
    } dev_req_t;

    localparam logic DEV_FUNC_READ  = 1'b0;
    localparam logic DEV_FUNC_WRITE = 1'b1;

endpackage

// File: rtl/device_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational (zero latency, no state).
// A lone requester always wins; on contention the port that did not win last time wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    assign grant_o[0] = valid_i[0] & (~valid_i[1] | last_grant_i);
    assign grant_o[1] = valid_i[1] & (~valid_i[0] | ~last_grant_i);

endmodule

// File: rtl/device_arbiter.sv
// Shares one Device port between fetch (0) and data (1): one transaction in flight, issue pulse at handshake+1.
// Requesters stall on req_ready outside IDLE; Device silence is bounded by a watchdog that returns an error response.
module device_arbiter
    import device_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 64,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in0_req_valid,
    output logic        in0_req_ready,
    input  logic [31:0] in0_req_bits_addr,
    input  logic [1:0]  in0_req_bits_len,
    input  logic [31:0] in0_req_bits_data,
    input  logic        in0_req_bits_func,
    input  logic [3:0]  in0_req_bits_strb,
    output logic        in0_resp_valid,
    output logic [31:0] in0_resp_bits_data,
    output logic        in0_resp_bits_err,
    input  logic        in1_req_valid,
    output logic        in1_req_ready,
    input  logic [31:0] in1_req_bits_addr,
    input  logic [1:0]  in1_req_bits_len,
    input  logic [31:0] in1_req_bits_data,
    input  logic        in1_req_bits_func,
    input  logic [3:0]  in1_req_bits_strb,
    output logic        in1_resp_valid,
    output logic [31:0] in1_resp_bits_data,
    output logic        in1_resp_bits_err,
    output logic        out_req_valid,
    output logic [31:0] out_req_bits_addr,
    output logic [1:0]  out_req_bits_len,
    output logic [31:0] out_req_bits_data,
    output logic        out_req_bits_func,
    output logic [3:0]  out_req_bits_strb,
    input  logic        out_resp_valid,
    input  logic [31:0] out_resp_bits_data
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    dev_req_t         req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [1:0]       grant;
    dev_req_t         in0_req, in1_req;

    assign in0_req = '{addr: in0_req_bits_addr, len: in0_req_bits_len, data: in0_req_bits_data,
                       func: in0_req_bits_func, strb: in0_req_bits_strb};
    assign in1_req = '{addr: in1_req_bits_addr, len: in1_req_bits_len, data: in1_req_bits_data,
                       func: in1_req_bits_func, strb: in1_req_bits_strb};

    rr_arb2 u_rr (
        .valid_i      ({in1_req_valid, in0_req_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // Ready is masked during reset so no requester sees a handshake the FSM cannot take.
    assign in0_req_ready = (state_q == ST_IDLE) & grant[0] & ~reset;
    assign in1_req_ready = (state_q == ST_IDLE) & grant[1] & ~reset;

    assign out_req_valid     = (state_q == ST_ISSUE);
    assign out_req_bits_addr = req_q.addr;
    assign out_req_bits_len  = req_q.len;
    assign out_req_bits_data = req_q.data;
    assign out_req_bits_func = req_q.func;
    assign out_req_bits_strb = req_q.strb;

    assign in0_resp_valid     = (state_q == ST_RESP) & ~owner_q;
    assign in1_resp_valid     = (state_q == ST_RESP) & owner_q;
    assign in0_resp_bits_data = rdata_q;
    assign in1_resp_bits_data = rdata_q;
    assign in0_resp_bits_err  = err_q;
    assign in1_resp_bits_err  = err_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    owner_d      = grant[1];
                    last_grant_d = grant[1];
                    req_d        = grant[1] ? in1_req : in0_req;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A real response beats the watchdog when both land in the same cycle.
                if (out_resp_valid) begin
                    rdata_d = out_resp_bits_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = TIMEOUT_DATA;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            req_q        <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_device_arbiter.sv
// Bench for device_arbiter (TIMEOUT = 8): request table plus round-robin, stray-response and reset sequences.
module tb_device_arbiter;
    import device_arb_pkg::*;

    localparam int unsigned TMO = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        in0_req_valid, in0_req_ready, in0_req_bits_func, in0_resp_valid, in0_resp_bits_err;
    logic [31:0] in0_req_bits_addr, in0_req_bits_data, in0_resp_bits_data;
    logic [1:0]  in0_req_bits_len;
    logic [3:0]  in0_req_bits_strb;
    logic        in1_req_valid, in1_req_ready, in1_req_bits_func, in1_resp_valid, in1_resp_bits_err;
    logic [31:0] in1_req_bits_addr, in1_req_bits_data, in1_resp_bits_data;
    logic [1:0]  in1_req_bits_len;
    logic [3:0]  in1_req_bits_strb;
    logic        out_req_valid, out_req_bits_func, out_resp_valid;
    logic [31:0] out_req_bits_addr, out_req_bits_data, out_resp_bits_data;
    logic [1:0]  out_req_bits_len;
    logic [3:0]  out_req_bits_strb;

    logic        dev_vld = 1'b0;
    logic [31:0] dev_data = '0;
    logic        stray = 1'b0;
    assign out_resp_valid     = dev_vld | stray;
    assign out_resp_bits_data = dev_vld ? dev_data : 32'hBAD0_BAD0;

    device_arbiter #(.TIMEOUT(TMO), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
        .clock(clock), .reset(reset),
        .in0_req_valid(in0_req_valid), .in0_req_ready(in0_req_ready),
        .in0_req_bits_addr(in0_req_bits_addr), .in0_req_bits_len(in0_req_bits_len),
        .in0_req_bits_data(in0_req_bits_data), .in0_req_bits_func(in0_req_bits_func),
        .in0_req_bits_strb(in0_req_bits_strb), .in0_resp_valid(in0_resp_valid),
        .in0_resp_bits_data(in0_resp_bits_data), .in0_resp_bits_err(in0_resp_bits_err),
        .in1_req_valid(in1_req_valid), .in1_req_ready(in1_req_ready),
        .in1_req_bits_addr(in1_req_bits_addr), .in1_req_bits_len(in1_req_bits_len),
        .in1_req_bits_data(in1_req_bits_data), .in1_req_bits_func(in1_req_bits_func),
        .in1_req_bits_strb(in1_req_bits_strb), .in1_resp_valid(in1_resp_valid),
        .in1_resp_bits_data(in1_resp_bits_data), .in1_resp_bits_err(in1_resp_bits_err),
        .out_req_valid(out_req_valid), .out_req_bits_addr(out_req_bits_addr),
        .out_req_bits_len(out_req_bits_len), .out_req_bits_data(out_req_bits_data),
        .out_req_bits_func(out_req_bits_func), .out_req_bits_strb(out_req_bits_strb),
        .out_resp_valid(out_resp_valid), .out_resp_bits_data(out_resp_bits_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic        port;
        dev_req_t    req;
        int          dly;      // Device answers this many cycles after issue; 0 = never
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;  // handshake to resp_valid, in cycles
    } vec_t;
    typedef struct { dev_req_t req; int dly; logic [31:0] rdata; } iss_t;
    typedef struct { logic port; logic [31:0] data; logic err; int due; } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   n_cmp = 0, n_err = 0, n_rsp = 0;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event/none, expected the opposite (cycle %0d)", nm, cyc);
    endtask

    function automatic vec_t mk(input logic p, input logic [31:0] a, input logic [1:0] l,
                                input logic [31:0] d, input logic f, input logic [3:0] s,
                                input int dly, input logic [31:0] rd, input logic [31:0] ed,
                                input logic ee, input int lat);
        vec_t v;
        v.port = p; v.req = '{addr: a, len: l, data: d, func: f, strb: s};
        v.dly = dly; v.rdata = rd; v.exp_data = ed; v.exp_err = ee; v.exp_lat = lat;
        return v;
    endfunction

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'h0F0F_F0F0;
    endfunction

    function automatic dev_req_t port_req(input logic p);
        if (!p) return '{addr: in0_req_bits_addr, len: in0_req_bits_len, data: in0_req_bits_data,
                         func: in0_req_bits_func, strb: in0_req_bits_strb};
        return '{addr: in1_req_bits_addr, len: in1_req_bits_len, data: in1_req_bits_data,
                 func: in1_req_bits_func, strb: in1_req_bits_strb};
    endfunction

    task automatic set_port(input logic p, input logic v, input dev_req_t r);
        if (!p) begin
            in0_req_valid = v; in0_req_bits_addr = r.addr; in0_req_bits_len = r.len;
            in0_req_bits_data = r.data; in0_req_bits_func = r.func; in0_req_bits_strb = r.strb;
        end else begin
            in1_req_valid = v; in1_req_bits_addr = r.addr; in1_req_bits_len = r.len;
            in1_req_bits_data = r.data; in1_req_bits_func = r.func; in1_req_bits_strb = r.strb;
        end
    endtask

    task automatic wait_hs(output bit ok, output int t, output logic p);
        ok = 1'b0; t = 0; p = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            if (in0_req_valid && in0_req_ready) begin ok = 1'b1; p = 1'b0; t = cyc; end
            else if (in1_req_valid && in1_req_ready) begin ok = 1'b1; p = 1'b1; t = cyc; end
        end
        if (!ok) fail("handshake_timeout");
    endtask

    task automatic push_exp(input logic p, input dev_req_t r, input int dly, input logic [31:0] rd,
                            input bit exp_rsp, input logic [31:0] ed, input logic ee, input int due);
        iss_t e;
        rsp_t s;
        e.req = r; e.dly = dly; e.rdata = rd;
        iss_q.push_back(e);
        if (exp_rsp) begin
            s.port = p; s.data = ed; s.err = ee; s.due = due;
            rsp_q.push_back(s);
        end
    endtask

    // Called and returns at posedge+1; t is the handshake cycle.
    task automatic do_req(input vec_t v, input bit exp_rsp, output int t);
        bit   ok;
        logic p;
        set_port(v.port, 1'b1, v.req);
        wait_hs(ok, t, p);
        if (ok) begin
            chk("grant_port", p, v.port);
            push_exp(v.port, v.req, v.dly, v.rdata, exp_rsp, v.exp_data, v.exp_err, t + v.exp_lat);
        end
        @(posedge clock); #1;
        set_port(v.port, 1'b0, v.req);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && rsp_q.size() != 0; i++) @(negedge clock);
        if (rsp_q.size() != 0) fail("response_drain_timeout");
        @(posedge clock); #1;
    endtask

    initial begin
        fork
            begin : bg
                iss_t        e;
                rsp_t        r;
                logic        prev_iss;
                int          pend;
                logic [31:0] pend_data;
                prev_iss = 1'b0; pend = 0; pend_data = '0;
                forever begin
                    @(negedge clock);
                    if (out_req_valid === 1'b1) begin
                        chk("no_back_to_back_issue", prev_iss, 1'b0);
                        if (iss_q.size() == 0) fail("unexpected_issue");
                        else begin
                            e = iss_q.pop_front();
                            chk("issue_addr", out_req_bits_addr, e.req.addr);
                            chk("issue_len",  out_req_bits_len,  e.req.len);
                            chk("issue_data", out_req_bits_data, e.req.data);
                            chk("issue_func", out_req_bits_func, e.req.func);
                            chk("issue_strb", out_req_bits_strb, e.req.strb);
                            pend = e.dly; pend_data = e.rdata;
                        end
                    end
                    prev_iss = out_req_valid;
                    if (in0_resp_valid === 1'b1 && in1_resp_valid === 1'b1) fail("both_resp_valid");
                    else if (in0_resp_valid === 1'b1 || in1_resp_valid === 1'b1) begin
                        n_rsp++;
                        if (rsp_q.size() == 0) fail("unexpected_resp");
                        else begin
                            r = rsp_q.pop_front();
                            chk("resp_port", in1_resp_valid, r.port);
                            chk("resp_data", in1_resp_valid ? in1_resp_bits_data : in0_resp_bits_data, r.data);
                            chk("resp_err",  in1_resp_valid ? in1_resp_bits_err : in0_resp_bits_err, r.err);
                            chk("resp_cycle", cyc, r.due);
                        end
                    end
                    @(posedge clock); #1;
                    if (pend > 0) begin
                        pend--;
                        dev_vld  = (pend == 0);
                        dev_data = pend_data;
                    end else dev_vld = 1'b0;
                end
            end
            begin : main
                int       t, t_prev, n0;
                bit       ok;
                logic     p;
                dev_req_t r;
                vec_t     v;

                vecs[0] = mk(0, 32'h1000_0000, 2'd2, 32'h0, DEV_FUNC_READ,  4'hF, 1, 32'h1234_5678, 32'h1234_5678, 0, 3);
                vecs[1] = mk(1, 32'h2000_0010, 2'd1, 32'hCAFE_F00D, DEV_FUNC_WRITE, 4'b0011, 1, 32'h0, 32'h0, 0, 3);
                vecs[2] = mk(1, 32'h3000_0000, 2'd2, 32'h0, DEV_FUNC_READ,  4'hF, 0, 32'h0, 32'hDEAD_BEEF, 1, TMO + 2);
                vecs[3] = mk(0, 32'h3000_0004, 2'd2, 32'h0, DEV_FUNC_READ,  4'hF, 1, 32'h0000_0001, 32'h0000_0001, 0, 3);
                vecs[4] = mk(0, 32'h3000_0008, 2'd0, 32'h0, DEV_FUNC_READ,  4'h1, 3, 32'hA5A5_0003, 32'hA5A5_0003, 0, 5);
                vecs[5] = mk(1, 32'h3000_000C, 2'd2, 32'h0, DEV_FUNC_READ,  4'hF, TMO, 32'h5555_AAAA, 32'h5555_AAAA, 0, TMO + 2);
                vecs[6] = mk(0, 32'h3000_0010, 2'd2, 32'h0, DEV_FUNC_READ,  4'hF, TMO - 1, 32'h7777_0007, 32'h7777_0007, 0, TMO + 1);
                vecs[7] = mk(1, 32'h3000_0014, 2'd2, 32'h0, DEV_FUNC_READ,  4'hF, TMO + 1, 32'h9999_0009, 32'hDEAD_BEEF, 1, TMO + 2);

                // Both ports request during reset: ready must stay low.
                reset = 1'b1;
                set_port(0, 1'b1, '{addr: 32'h4000_0000, len: 2'd2, data: 32'h0, func: DEV_FUNC_READ, strb: 4'hF});
                set_port(1, 1'b1, '{addr: 32'h5000_0000, len: 2'd2, data: 32'h0, func: DEV_FUNC_READ, strb: 4'hF});
                #12;
                chk("rst_in0_ready", in0_req_ready, 1'b0);
                chk("rst_in1_ready", in1_req_ready, 1'b0);
                chk("rst_out_req_valid", out_req_valid, 1'b0);
                chk("rst_out_req_addr", out_req_bits_addr, 32'h0);
                chk("rst_resp_valids", {in0_resp_valid, in1_resp_valid}, 2'b00);
                chk("rst_resp_data", {in0_resp_bits_data, in1_resp_bits_data}, 64'h0);
                chk("rst_resp_err", {in0_resp_bits_err, in1_resp_bits_err}, 2'b00);
                @(posedge clock); #1;
                reset = 1'b0;

                // Held contention alternates 0,1,0,1 with a handshake every 4 cycles.
                t_prev = 0;
                for (int k = 0; k < 4; k++) begin
                    wait_hs(ok, t, p);
                    if (ok) begin
                        chk("rr_order", p, k[0]);
                        if (k > 0) chk("rr_hs_spacing", t - t_prev, 4);
                        t_prev = t;
                        r = port_req(p);
                        push_exp(p, r, 1, rdata_of(r.addr), 1'b1, rdata_of(r.addr), 1'b0, t + 3);
                        @(posedge clock); #1;
                        r.addr = r.addr + 32'd4;
                        set_port(p, 1'b1, r);
                    end
                end
                in0_req_valid = 1'b0;
                in1_req_valid = 1'b0;
                drain();

                foreach (vecs[i]) begin
                    do_req(vecs[i], 1'b1, t);
                end
                drain();

                // Stray Device response in IDLE, then again while a response is being returned.
                n0 = n_rsp;
                stray = 1'b1;
                @(posedge clock); #1;
                stray = 1'b0;
                repeat (2) begin @(posedge clock); #1; end
                chk("stray_idle_no_resp", n_rsp, n0);
                v = mk(0, 32'h7000_0000, 2'd2, 32'h0, DEV_FUNC_READ, 4'hF, 1, 32'hABCD_0001, 32'hABCD_0001, 0, 3);
                do_req(v, 1'b1, t);
                repeat (2) begin @(posedge clock); #1; end
                stray = 1'b1;
                @(posedge clock); #1;
                stray = 1'b0;
                repeat (3) begin @(posedge clock); #1; end
                chk("stray_resp_count", n_rsp - n0, 1);
                drain();

                // Reset mid-WAIT; the Device answers late, after reset has been released.
                v = mk(0, 32'h6000_0000, 2'd2, 32'h0, DEV_FUNC_READ, 4'hF, 6, 32'h6666_0006, 32'h0, 0, 0);
                do_req(v, 1'b0, t);
                @(posedge clock); #3;
                in1_req_valid = 1'b1;
                reset = 1'b1;
                #1;
                chk("arst_in1_ready", in1_req_ready, 1'b0);
                chk("arst_out_req_valid", out_req_valid, 1'b0);
                chk("arst_out_req_addr", out_req_bits_addr, 32'h0);
                chk("arst_resp_valids", {in0_resp_valid, in1_resp_valid}, 2'b00);
                chk("arst_resp_data", in0_resp_bits_data, 32'h0);
                n0 = n_rsp;
                @(posedge clock); #1;
                @(posedge clock); #1;
                in1_req_valid = 1'b0;
                reset = 1'b0;
                repeat (4) begin @(posedge clock); #1; end
                chk("arst_no_resp", n_rsp, n0);
                v = mk(1, 32'h6000_0100, 2'd2, 32'h0, DEV_FUNC_READ, 4'hF, 1, 32'h1111_2222, 32'h1111_2222, 0, 3);
                do_req(v, 1'b1, t);
                drain();
                chk("iss_queue_empty", iss_q.size(), 0);

                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        join
    end

endmodule

// File: doc/device_arbiter.md
# device_arbiter

Two-requester arbiter that shares the single memory-mapped `Device` request/response port between the instruction-fetch side (port 0) and the data-memory side (port 1) of the M2 core. It accepts one transaction at a time and issues it to the Device as a single-cycle `req_valid` pulse, because the Device performs its I/O side effect on every valid cycle. It then routes the Device response back to the owning port, with round-robin fairness and a response watchdog.

## Interface
- `TIMEOUT`, default 64: cycles to wait in WAIT for `out_resp_valid` before forcing an error response; must be ≥ 2.
- `TIMEOUT_DATA`, default 32'hDEAD_BEEF: data returned on timeout.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in{0,1}_req_valid`  in  1  requester has a transaction.
- `in{0,1}_req_ready`  out  1  transaction accepted this cycle.
- `in{0,1}_req_bits_addr`  in  32  byte address.
- `in{0,1}_req_bits_len`  in  2  access size code, passed through.
- `in{0,1}_req_bits_data`  in  32  write data.
- `in{0,1}_req_bits_func`  in  1  0 = read, 1 = write.
- `in{0,1}_req_bits_strb`  in  4  byte strobes.
- `in{0,1}_resp_valid`  out  1  one-cycle response pulse to the owner.
- `in{0,1}_resp_bits_data`  out  32  response data.
- `in{0,1}_resp_bits_err`  out  1  1 = watchdog timeout.
- `out_req_valid`  out  1  single-cycle issue pulse to the Device.
- `out_req_bits_{addr,len,data,func,strb}`  out  32/2/32/1/4  latched request.
- `out_resp_valid`  in  1  Device response valid.
- `out_resp_bits_data`  in  32  Device response data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - If exactly one `inN_req_valid` is high, that port is granted.
  - If both are high, grant goes to the port that is not `last_grant`.
  - `inN_req_ready` is combinational: high only in IDLE, and only for the granted port.
  - On the handshake: latch the request fields and owner, set `last_grant` to the owner, go to ISSUE.
- **ISSUE**
  - `out_req_valid` = 1 for exactly this cycle; the `out_req_bits_*` fields hold the latched values.
  - Clear the watchdog counter and go to WAIT.
- **WAIT**
  - `out_req_valid` = 0 and the counter increments each cycle.
  - If `out_resp_valid` = 1: latch `out_resp_bits_data`, set err = 0, go to RESP.
  - Otherwise, if the counter reaches TIMEOUT−1: latch TIMEOUT_DATA, set err = 1, go to RESP.
  - If both happen in the same cycle, the real response wins.
- **RESP**
  - Owner's `resp_valid` = 1 for one cycle with the latched data and err; the other port sees `resp_valid` = 0.
  - Go to IDLE.
- `out_resp_valid` outside WAIT is ignored and drops no state.
- The `out_req_bits_*` fields hold their last latched value outside ISSUE.
- Requester rules:
  - A requester may drop `req_valid` before it is granted; no transaction is issued for it.
  - Requester fields are sampled only at the handshake.
- Reset asserted mid-transaction:
  - Immediately: state = IDLE, `last_grant` = 1, counter = 0, latched data/err = 0; all valid and ready outputs are 0 while reset is high.
  - The in-flight transaction is abandoned with no response.
  - A late Device response after reset is ignored.

## Timing
- Reset values:
  - All `resp_valid` and `resp_bits_*` = 0.
  - All `req_ready` = 0 while reset is high.
  - `out_req_valid` = 0; `out_req_bits_*` = 0.
- With the Device responding one cycle after issue:
  - Handshake at cycle t.
  - `out_req_valid` at t+1.
  - `out_resp_valid` at t+2.
  - `inN_resp_valid` at t+3.
  - Next handshake possible at t+4.
- Timeout path: `resp_valid` with err = 1 exactly TIMEOUT+2 cycles after the handshake.
- At most one Device transaction is outstanding; `out_req_valid` is never high on two consecutive cycles.

## Structure
- Package `device_arb_pkg`:
  - `arb_state_t` enum.
  - `dev_req_t` struct {addr, len, data, func, strb}.
  - `DEV_FUNC_READ` / `DEV_FUNC_WRITE` constants.
- Sub-module `rr_arb2`: combinational two-way round-robin grant (inputs: valid[1:0], last_grant; output: one-hot grant).
- FSM, request/response latches and watchdog counter live in `device_arbiter`; counter width is $clog2(TIMEOUT)+1.

## Test plan
- **Single read:** port 0 reads addr 32'h1000_0000; Device returns 32'h1234_5678 one cycle after issue.
  - `in0_resp_valid` with that data and err = 0 at handshake+3.
  - `out_req_valid` high for exactly 1 cycle.
- **Simultaneous requests from reset:**
  - Both ports request; port 0 is granted first, port 1 second.
  - With both held continuously, grants alternate 0,1,0,1.
- **Write pass-through:** port 1 writes data 32'hCAFE_F00D, strb 4'b0011, len 2'd1, func 1.
  - `out_req_bits_*` match exactly during the single ISSUE cycle.
  - `in0_resp_valid` stays 0 throughout.
- **Watchdog:** TIMEOUT = 8 and the Device never responds.
  - `in1_resp_valid` with data 32'hDEAD_BEEF and err = 1 at handshake+10.
  - The next request is accepted normally.
- **Stray response:** `out_resp_valid` pulsed while in IDLE, then again during RESP → no `resp_valid` on either port; the FSM is unaffected.
- **Reset in WAIT:**
  - Assert reset asynchronously, mid-cycle → outputs clear before the next edge, and no response is produced.
  - Deassert reset, then issue a port 1 request → it completes normally at handshake+3.
